mux_key: RTL and testbench
==========================

Name: mux_key

Overview:
- Parameterised key-to-data lookup multiplexer (content-addressed mux).
- Compares `key` against NR_KEY constant/wired keys packed in a flat lookup vector and drives the data paired with the matching key.
- Used throughout the core datapath for next-PC operand selection (PC+4 vs PC+imm, pc vs rs1) and CSR-address-to-index decoding.
- Combinational by default; an optional registered output stage exists.

Parameters:
- NR_KEY, 2, number of key/data pairs (>=1).
- KEY_LEN, 1, width of `key` and of each stored key (>=1).
- DATA_LEN, 1, width of each data word and of `out` (>=1).

Ports:
- clk  input  1  clock; used only when the output register is compiled in.
- rst  input  1  reset; synchronous, active-high; used only when the output register is compiled in.
- out  output  DATA_LEN  selected data.
- key  input  KEY_LEN  lookup key.
- lut  input  NR_KEY*(KEY_LEN+DATA_LEN)  packed pairs.
- hit  output  1  high when any stored key equals `key`.
- Interface: reset rst, synchronous, active-high; clock clk.
- Instances connect by name.

Behaviour:
- PAIR = KEY_LEN+DATA_LEN. Pair i (i=0..NR_KEY-1) occupies `lut` bits [(NR_KEY-i)*PAIR-1 -: PAIR].
  - Pair 0 is the most-significant, i.e. the first pair written in a concatenation {k0,d0,k1,d1,...}.
  - Within a pair, the key is the upper KEY_LEN bits and the data is the lower DATA_LEN bits.
- Match_i = (key == key_i), full-width equality. No X/Z wildcard matching.
- `out` = data of the lowest-index matching pair. Duplicate keys: the first-listed pair wins.
- No match: `out` = all zeros, `hit` = 0.
- `hit` = OR of all match_i.
- Combinational mode (default):
  - Zero latency. `out` and `hit` follow `key`/`lut` within the same cycle.
  - No state. clk and rst are ignored.
- NR_KEY=1: single comparator. `out` = d0 on match, else 0.
- Purely structural. No latches. Every output is fully assigned on every path.

Optional Feature:
- Macro: MUX_KEY_REG_OUT_EN.
- Defined:
  - `out` and `hit` are registered on posedge clk. Latency is 1 cycle.
  - rst=1 at a posedge: `out` <= 0 and `hit` <= 0. rst has priority over the lookup.
  - Reset asserted mid-operation zeroes the outputs at the next edge. The first valid result appears at the first edge after rst deasserts.
  - Equality, priority and no-match rules are identical to combinational mode.
- Undefined:
  - Combinational mode as above.
  - clk and rst remain in the port list but are unused.

Decomposition:
- Package mux_key_pkg holds a function pair_width(key_len,data_len).
- It also holds the shared CSR index constants used as data values: MEPC=2'b00, MSTATUS=2'b01, MCAUSE=2'b10, MTVEC=2'b11.
- One sub-module, mux_key_match: compares one pair and outputs match plus data gated by match.
- The top generates NR_KEY instances and a priority-select chain.

Test Plan:
- NR_KEY=4, KEY_LEN=32, DATA_LEN=2; lut={0x300,1, 0x305,3, 0x341,0, 0x342,2}:
  - key=0x305 -> out=3, hit=1.
  - key=0x342 -> out=2, hit=1.
  - key=0x300 -> out=1, hit=1.
- Same lut, key=0x123 -> out=0, hit=0.
- NR_KEY=2, KEY_LEN=1, DATA_LEN=32, lut={0,0x4, 1,imm}:
  - key=0 -> out=0x00000004.
  - key=1 with imm=0xFFFFF000 -> out=0xFFFFF000.
- Duplicate keys, lut={5,0xA, 5,0xB} (KEY_LEN=4, DATA_LEN=4):
  - key=5 -> out=0xA (first pair wins).
- Randomised key/lut sweep over 1000 vectors vs behavioural model: out and hit match every cycle. Data wider than key (DATA_LEN=32, KEY_LEN=1) is covered.
- MUX_KEY_REG_OUT_EN defined:
  - key=0x305 at edge n -> out=3 visible after edge n+1.
  - rst=1 mid-stream -> out=0, hit=0 after the next edge.
  - First valid output arrives one edge after rst falls.

Source files
------------

// File: rtl/mux_key_pkg.sv
// Shared definitions for the key-to-data lookup mux: pair sizing helper and
// the CSR index values that CSR-address decode tables store as data.
package mux_key_pkg;

  localparam logic [1:0] MEPC    = 2'b00;
  localparam logic [1:0] MSTATUS = 2'b01;
  localparam logic [1:0] MCAUSE  = 2'b10;
  localparam logic [1:0] MTVEC   = 2'b11;

  function automatic int pair_width(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction

endpackage

// File: rtl/mux_key_match.sv
// One key/data pair comparator: exact full-width key equality, data forced
// to zero when the pair does not match so the caller can chain freely.
module mux_key_match
  import mux_key_pkg::*;
#(
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic [KEY_LEN-1:0]  i_key,
  input  logic [KEY_LEN-1:0]  i_pair_key,
  input  logic [DATA_LEN-1:0] i_pair_data,
  output logic                o_match,
  output logic [DATA_LEN-1:0] o_data
);

  logic w_match;

  assign w_match = (i_key == i_pair_key);
  assign o_match = w_match;
  assign o_data  = w_match ? i_pair_data : '0;

endmodule

// File: rtl/mux_key.sv
// Content-addressed mux: drives the data of the lowest-index pair whose key
// equals `key`. Define MUX_KEY_REG_OUT_EN to register out/hit (1-cycle latency).
module mux_key
  import mux_key_pkg::*;
#(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic [DATA_LEN-1:0]                   out,
  input  logic [KEY_LEN-1:0]                    key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
  output logic                                  hit
);

  localparam int PAIR = pair_width(KEY_LEN, DATA_LEN);

  logic [NR_KEY-1:0]   w_match;
  logic [DATA_LEN-1:0] w_data  [NR_KEY];
  logic [DATA_LEN-1:0] w_chain [NR_KEY+1];
  logic [DATA_LEN-1:0] w_out;
  logic                w_hit;

  // Chain is built from the last pair toward pair 0 so lower indices win.
  assign w_chain[NR_KEY] = '0;

  for (genvar i = 0; i < NR_KEY; i++) begin : g_pair
    logic [PAIR-1:0] w_pair;

    assign w_pair = lut[(NR_KEY-i)*PAIR-1 -: PAIR];

    mux_key_match #(
      .KEY_LEN  (KEY_LEN),
      .DATA_LEN (DATA_LEN)
    ) u_match (
      .i_key       (key),
      .i_pair_key  (w_pair[PAIR-1 -: KEY_LEN]),
      .i_pair_data (w_pair[DATA_LEN-1:0]),
      .o_match     (w_match[i]),
      .o_data      (w_data[i])
    );

    assign w_chain[i] = w_match[i] ? w_data[i] : w_chain[i+1];
  end

  assign w_out = w_chain[0];
  assign w_hit = |w_match;

`ifdef MUX_KEY_REG_OUT_EN
  logic [DATA_LEN-1:0] r_out;
  logic                r_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_hit <= 1'b0;
    end else begin
      r_out <= w_out;
      r_hit <= w_hit;
    end
  end

  assign out = r_out;
  assign hit = r_hit;
`else
  // Clock and reset stay on the port list so both builds share one footprint.
  logic w_unused;
  assign w_unused = clk ^ rst;

  assign out = w_out;
  assign hit = w_hit;
`endif

endmodule

// File: tb/tb_mux_key.sv
// Directed and model-checked bench for mux_key; also covers the registered
// output build when MUX_KEY_REG_OUT_EN is defined.
module tb_mux_key;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // CSR decode: 4 pairs, 32-bit key, 2-bit data
  logic [31:0]  csr_key;
  logic [135:0] csr_lut;
  logic [1:0]   csr_out;
  logic         csr_hit;

  // next-PC select: 2 pairs, 1-bit key, 32-bit data
  logic         pc_key;
  logic [65:0]  pc_lut;
  logic [31:0]  pc_out;
  logic         pc_hit;

  // duplicate-key check: 2 pairs, 4-bit key, 4-bit data
  logic [3:0]   dup_key;
  logic [15:0]  dup_lut;
  logic [3:0]   dup_out;
  logic         dup_hit;

  // single pair
  logic [3:0]   one_key;
  logic [7:0]   one_lut;
  logic [3:0]   one_out;
  logic         one_hit;

  // random sweep: 4 pairs, 3-bit key, 8-bit data
  logic [2:0]   rnd_key;
  logic [43:0]  rnd_lut;
  logic [7:0]   rnd_out;
  logic         rnd_hit;

  mux_key #(.NR_KEY(4), .KEY_LEN(32), .DATA_LEN(2)) u_csr (
    .clk(clk), .rst(rst), .out(csr_out), .key(csr_key), .lut(csr_lut), .hit(csr_hit));
  mux_key #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32)) u_pc (
    .clk(clk), .rst(rst), .out(pc_out), .key(pc_key), .lut(pc_lut), .hit(pc_hit));
  mux_key #(.NR_KEY(2), .KEY_LEN(4), .DATA_LEN(4)) u_dup (
    .clk(clk), .rst(rst), .out(dup_out), .key(dup_key), .lut(dup_lut), .hit(dup_hit));
  mux_key #(.NR_KEY(1), .KEY_LEN(4), .DATA_LEN(4)) u_one (
    .clk(clk), .rst(rst), .out(one_out), .key(one_key), .lut(one_lut), .hit(one_hit));
  mux_key #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(8)) u_rnd (
    .clk(clk), .rst(rst), .out(rnd_out), .key(rnd_key), .lut(rnd_lut), .hit(rnd_hit));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Let inputs take effect: one edge in the registered build, a delta otherwise.
  task automatic settle();
`ifdef MUX_KEY_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  // Reference lookup: scan from the last pair to the first, so the earliest
  // matching pair is the last one written.
  function automatic void model(input logic [127:0] lut, input logic [63:0] key,
                                input int nr, input int kl, input int dl,
                                output logic [63:0] o, output logic h);
    o = '0;
    h = 1'b0;
    for (int i = nr - 1; i >= 0; i--) begin
      int          base;
      logic        eq;
      logic [63:0] d;
      base = (nr - 1 - i) * (kl + dl);
      eq   = 1'b1;
      d    = '0;
      for (int b = 0; b < kl; b++)
        if (lut[base + dl + b] !== key[b]) eq = 1'b0;
      for (int b = 0; b < dl; b++)
        d[b] = lut[base + b];
      if (eq) begin
        o = d;
        h = 1'b1;
      end
    end
  endfunction

  initial begin
    logic [63:0] m_out;
    logic        m_hit;

    csr_lut = {32'h300, 2'd1, 32'h305, 2'd3, 32'h341, 2'd0, 32'h342, 2'd2};
    csr_key = 32'h305;
    pc_lut  = {1'b0, 32'h0000_0004, 1'b1, 32'hFFFF_F000};
    pc_key  = 1'b0;
    dup_lut = {4'h5, 4'hA, 4'h5, 4'hB};
    dup_key = 4'h5;
    one_lut = {4'h9, 4'h7};
    one_key = 4'h9;
    rnd_lut = '0;
    rnd_key = '0;

    repeat (2) @(posedge clk);
    #1;
`ifdef MUX_KEY_REG_OUT_EN
    check("reset_out", 64'(csr_out), 64'd0);
    check("reset_hit", 64'(csr_hit), 64'd0);
`else
    check("comb_out_in_reset", 64'(csr_out), 64'd3);
    check("comb_hit_in_reset", 64'(csr_hit), 64'd1);
`endif
    rst = 1'b0;

    csr_key = 32'h305; settle();
    check("csr_305_out", 64'(csr_out), 64'd3);
    check("csr_305_hit", 64'(csr_hit), 64'd1);
    csr_key = 32'h342; settle();
    check("csr_342_out", 64'(csr_out), 64'd2);
    check("csr_342_hit", 64'(csr_hit), 64'd1);
    csr_key = 32'h300; settle();
    check("csr_300_out", 64'(csr_out), 64'd1);
    check("csr_341_pre", 64'(csr_hit), 64'd1);
    csr_key = 32'h341; settle();
    check("csr_341_out", 64'(csr_out), 64'd0);
    check("csr_341_hit", 64'(csr_hit), 64'd1);
    csr_key = 32'h123; settle();
    check("csr_miss_out", 64'(csr_out), 64'd0);
    check("csr_miss_hit", 64'(csr_hit), 64'd0);
    csr_key = 32'h8000_0305; settle();
    check("csr_upper_bit_hit", 64'(csr_hit), 64'd0);

    pc_key = 1'b0; settle();
    check("pc_plus4", 64'(pc_out), 64'h0000_0004);
    pc_key = 1'b1; settle();
    check("pc_imm", 64'(pc_out), 64'hFFFF_F000);
    check("pc_imm_hit", 64'(pc_hit), 64'd1);

    dup_key = 4'h5; settle();
    check("dup_first_wins", 64'(dup_out), 64'hA);
    dup_key = 4'h3; settle();
    check("dup_miss_out", 64'(dup_out), 64'h0);
    check("dup_miss_hit", 64'(dup_hit), 64'd0);
    dup_lut = {4'h5, 4'hA, 4'h6, 4'hB}; dup_key = 4'h6; settle();
    check("dup_second_pair", 64'(dup_out), 64'hB);

    one_key = 4'h9; settle();
    check("one_match_out", 64'(one_out), 64'h7);
    check("one_match_hit", 64'(one_hit), 64'd1);
    one_key = 4'h8; settle();
    check("one_miss_out", 64'(one_out), 64'h0);
    check("one_miss_hit", 64'(one_hit), 64'd0);

    for (int v = 0; v < 500; v++) begin
      rnd_lut = {12'($urandom), 32'($urandom)};
      rnd_key = 3'($urandom);
      pc_lut  = {2'($urandom), 32'($urandom), 32'($urandom)};
      pc_key  = 1'($urandom);
      settle();
      model(128'(rnd_lut), 64'(rnd_key), 4, 3, 8, m_out, m_hit);
      check("rnd_out", 64'(rnd_out), m_out);
      check("rnd_hit", 64'(rnd_hit), 64'(m_hit));
      model(128'(pc_lut), 64'(pc_key), 2, 1, 32, m_out, m_hit);
      check("pcr_out", 64'(pc_out), m_out);
      check("pcr_hit", 64'(pc_hit), 64'(m_hit));
    end

`ifdef MUX_KEY_REG_OUT_EN
    @(negedge clk);
    csr_key = 32'h123;
    @(posedge clk); #1;
    @(negedge clk);
    csr_key = 32'h305;
    #1;
    check("reg_before_edge", 64'(csr_out), 64'd0);
    @(posedge clk); #1;
    check("reg_after_edge_out", 64'(csr_out), 64'd3);
    check("reg_after_edge_hit", 64'(csr_hit), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reg_midrst_out", 64'(csr_out), 64'd0);
    check("reg_midrst_hit", 64'(csr_hit), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reg_rst_fall_out", 64'(csr_out), 64'd0);
    @(posedge clk); #1;
    check("reg_first_valid_out", 64'(csr_out), 64'd3);
    check("reg_first_valid_hit", 64'(csr_hit), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
